neuron_wb_master: RTL

Wishbone classic single-transfer master that issues the register reads and writes the neuron parameter slaves (base 0x3000_4000, three 32-bit words per neuron) respond to. It accepts commands from a local controller through a valid/ready port and buffers them in a small FIFO. It runs one Wishbone cycle per command and returns a single-cycle response pulse with read data or a timeout error. It sits between the on-chip sequencer and the Wishbone interconnect, replacing the management core as bus initiator during autonomous parameter loading.

---
 rtl/neuron_wb_pkg.sv | 29 ++
 rtl/neuron_wb_cmd_fifo.sv | 53 +++++
 rtl/neuron_wb_master.sv | 139 +++++++++++++
 3 files changed

// File: rtl/neuron_wb_pkg.sv
// Shared types and constants for the neuron parameter Wishbone master.
// Command words are packed as {we, sel, adr, dat}.
package neuron_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2
  } wb_state_t;

  localparam int CMD_W = 69;

  localparam logic [31:0] NEURON_PARAM_BASE   = 32'h3000_4000;
  localparam int          NEURON_PARAM_STRIDE = 12;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } wb_cmd_t;

  // Byte address of parameter word 'word' (0..2) of neuron 'neuron'.
  function automatic logic [31:0] neuron_param_adr(input logic [15:0] neuron,
                                                   input logic [1:0]  word);
    return NEURON_PARAM_BASE + 32'(neuron) * 32'(NEURON_PARAM_STRIDE) + {28'd0, word, 2'b00};
  endfunction

endpackage

// File: rtl/neuron_wb_cmd_fifo.sv
// Synchronous FIFO with registered occupancy count; the head entry is read
// combinationally so the consumer can pop and use it on the same edge.
module neuron_wb_cmd_fifo #(
  parameter int WIDTH = 69,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/neuron_wb_master.sv
// Wishbone classic single-transfer master: drains queued commands one bus
// cycle at a time and returns a one-cycle response with read data or timeout.
module neuron_wb_master
  import neuron_wb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_we_i,
  input  logic [3:0]  cmd_sel_i,
  input  logic [31:0] cmd_adr_i,
  input  logic [31:0] cmd_dat_i,
  output logic        rsp_valid_o,
  output logic        rsp_we_o,
  output logic        rsp_err_o,
  output logic [31:0] rsp_dat_o,
  output logic        busy_o,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic        wbm_ack_i,
  input  logic [31:0] wbm_dat_i
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT);

  wb_state_t        state_q;
  wb_state_t        state_d;
  logic [CMD_W-1:0] push_word;
  logic [CMD_W-1:0] head_word;
  wb_cmd_t          head_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_cnt;
  logic             pop;
  logic             bus_done;
  logic             tmo_hit;
  logic [TW-1:0]    tmo_cnt;
  logic [TW-1:0]    tmo_inc;

  assign push_word   = {cmd_we_i, cmd_sel_i, cmd_adr_i, cmd_dat_i};
  assign head_cmd    = head_word;
  assign cmd_ready_o = !fifo_full;
  assign busy_o      = (fifo_cnt != '0) || wbm_cyc_o;
  assign tmo_inc     = tmo_cnt + 1'b1;

  neuron_wb_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (cmd_valid_i && cmd_ready_o),
    .pop   (pop),
    .wdata (push_word),
    .rdata (head_word),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // The counter holds cycles already waited, so the limit is hit on the edge
  // that would complete the TIMEOUT-th strobe cycle.
  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    bus_done = 1'b0;
    tmo_hit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (wbm_ack_i) begin
          bus_done = 1'b1;
          state_d  = ST_GAP;
        end else if ((TIMEOUT != 0) && (tmo_inc == TMO_LIM)) begin
          bus_done = 1'b1;
          tmo_hit  = 1'b1;
          state_d  = ST_GAP;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q     <= ST_IDLE;
      tmo_cnt     <= '0;
      wbm_cyc_o   <= 1'b0;
      wbm_stb_o   <= 1'b0;
      wbm_we_o    <= 1'b0;
      wbm_sel_o   <= '0;
      wbm_adr_o   <= '0;
      wbm_dat_o   <= '0;
      rsp_valid_o <= 1'b0;
      rsp_we_o    <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_dat_o   <= '0;
    end else begin
      state_q     <= state_d;
      rsp_valid_o <= 1'b0;
      if (pop) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= head_cmd.we;
        wbm_sel_o <= head_cmd.sel;
        wbm_adr_o <= head_cmd.adr;
        wbm_dat_o <= head_cmd.dat;
        tmo_cnt   <= '0;
      end
      if ((state_q == ST_BUS) && !bus_done) tmo_cnt <= tmo_inc;
      // Address/data stay parked after the cycle ends; only cyc/stb drop.
      if (bus_done) begin
        wbm_cyc_o   <= 1'b0;
        wbm_stb_o   <= 1'b0;
        rsp_valid_o <= 1'b1;
        rsp_we_o    <= wbm_we_o;
        rsp_err_o   <= tmo_hit;
        rsp_dat_o   <= (tmo_hit || wbm_we_o) ? 32'd0 : wbm_dat_i;
      end
    end
  end

endmodule
